// File: rtl/iob_sticky_shift_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iob_sticky_shift_pkg
// Description : Shared helpers for the sticky right-alignment shifter.
//               ceil_div   - integer ceiling division used to size the shift
//                            slice handled by each pipeline stage.
//               stage_mask - bit mask selecting the shift-amount bits a given
//                            stage consumes (LSB group first).
// Revision    : 1.0 - initial release
// ============================================================================
package iob_sticky_shift_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Stage idx owns shift bits [idx*group_w +: group_w], clipped to shift_w.
  // Trailing stages may own no bits at all and then simply pass data through.
  function automatic logic [31:0] stage_mask(input int shift_w, input int idx,
                                             input int group_w);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 32; b++) begin
      if ((b < shift_w) && (b >= idx * group_w) && (b < (idx + 1) * group_w)) begin
        mask[b] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_sticky_shift_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iob_sticky_shift_stage
// Description : One registered group of the sticky shifter. Shifts the
//               extended word {man, g, r} right by this stage's slice of the
//               shift amount, ORs every bit leaving the r slot into sticky,
//               and forwards the still-unconsumed shift bits and valid.
// Ports       : clk_i, rst_i      clock / synchronous active-high reset
//               en_i              global advance; all registers hold when 0
//               valid_i/valid_o   stage occupancy
//               ext_i/ext_o       EXT_W-bit {man, g, r} word
//               sticky_i/sticky_o accumulated sticky flag
//               shift_i/shift_o   remaining shift amount
// Revision    : 1.0 - initial release
// ============================================================================
module iob_sticky_shift_stage
  import iob_sticky_shift_pkg::*;
#(
  parameter int EXT_W         = 26,
  parameter int SHIFT_W       = 5,
  parameter int STAGE_SHIFT_W = 3,
  parameter int IDX           = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [EXT_W-1:0]   ext_i,
  input  logic               sticky_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               valid_o,
  output logic [EXT_W-1:0]   ext_o,
  output logic               sticky_o,
  output logic [SHIFT_W-1:0] shift_o
);

  localparam logic [31:0]        MASK_ALL = stage_mask(SHIFT_W, IDX, STAGE_SHIFT_W);
  localparam logic [SHIFT_W-1:0] MASK     = MASK_ALL[SHIFT_W-1:0];

  logic [SHIFT_W-1:0] amt;
  logic [EXT_W-1:0]   shifted;
  logic [EXT_W-1:0]   lost_mask;
  logic               lost;

  // Masking in place keeps the bit weights, so amt is already the shift
  // distance for this stage.
  assign amt       = shift_i & MASK;
  assign shifted   = ext_i >> amt;
  assign lost_mask = ~({EXT_W{1'b1}} << amt);
  assign lost      = |(ext_i & lost_mask);

  logic               valid_q,  valid_d;
  logic [EXT_W-1:0]   ext_q,    ext_d;
  logic               sticky_q, sticky_d;
  logic [SHIFT_W-1:0] shift_q,  shift_d;

  always_comb begin
    valid_d  = valid_q;
    ext_d    = ext_q;
    sticky_d = sticky_q;
    shift_d  = shift_q;
    if (en_i) begin
      valid_d  = valid_i;
      ext_d    = shifted;
      sticky_d = sticky_i | lost;
      shift_d  = shift_i & ~MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      ext_q    <= '0;
      sticky_q <= 1'b0;
      shift_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ext_q    <= ext_d;
      sticky_q <= sticky_d;
      shift_q  <= shift_d;
    end
  end

  assign valid_o  = valid_q;
  assign ext_o    = ext_q;
  assign sticky_o = sticky_q;
  assign shift_o  = shift_q;

endmodule
`default_nettype wire

// File: rtl/iob_sticky_shift.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iob_sticky_shift
// Description : Pipelined right-alignment shifter for float mantissas.
//               man_o = man_i >> shift_i with guard, round and sticky bits.
//               Latency STAGES cycles, one result per cycle, valid/ready on
//               both sides with a single global advance enable.
// Ports       : clk_i, rst_i          clock / synchronous active-high reset
//               valid_i, ready_o      input handshake
//               man_i, shift_i        mantissa and right-shift amount
//               valid_o, ready_i      output handshake
//               man_o                 shifted mantissa
//               guard_o, round_o      first / second bit below man_o LSB
//               sticky_o              OR of all bits below the round position
//               carry_o               (IOB_STICKY_SHIFT_RND_EN only) overflow
//                                     of the round-to-nearest-even increment
// Config      : define IOB_STICKY_SHIFT_RND_EN to add a rounding output stage
//               (latency STAGES+1, man_o rounded, grs report pre-round values)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_sticky_shift
  import iob_sticky_shift_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int SHIFT_W = 5,
  parameter int STAGES  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [DATA_W-1:0]  man_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  man_o,
  output logic               guard_o,
  output logic               round_o,
  output logic               sticky_o
`ifdef IOB_STICKY_SHIFT_RND_EN
  ,
  output logic               carry_o
`endif
);

  localparam int          EXT_W         = DATA_W + 2;
  localparam int          STAGE_SHIFT_W = ceil_div(SHIFT_W, STAGES);
  localparam logic [31:0] SAT_THR       = 32'(DATA_W + 2);

  logic en;
  logic sat;

  // Index k is the input of stage k; index STAGES is the last stage output.
  logic               valid_c  [STAGES+1];
  logic [EXT_W-1:0]   ext_c    [STAGES+1];
  logic               sticky_c [STAGES+1];
  logic [SHIFT_W-1:0] shift_c  [STAGES+1];

  // Any shift past the round slot pushes the whole mantissa into sticky, so
  // resolve it up front and let the stages see a zero shift.
  assign sat         = 32'(shift_i) >= SAT_THR;
  assign valid_c[0]  = valid_i;
  assign ext_c[0]    = sat ? '0 : {man_i, 2'b00};
  assign sticky_c[0] = sat & (|man_i);
  assign shift_c[0]  = sat ? '0 : shift_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    iob_sticky_shift_stage #(
      .EXT_W         (EXT_W),
      .SHIFT_W       (SHIFT_W),
      .STAGE_SHIFT_W (STAGE_SHIFT_W),
      .IDX           (k)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en),
      .valid_i  (valid_c[k]),
      .ext_i    (ext_c[k]),
      .sticky_i (sticky_c[k]),
      .shift_i  (shift_c[k]),
      .valid_o  (valid_c[k+1]),
      .ext_o    (ext_c[k+1]),
      .sticky_o (sticky_c[k+1]),
      .shift_o  (shift_c[k+1])
    );
  end

`ifdef IOB_STICKY_SHIFT_RND_EN
  logic [DATA_W-1:0] pre_man;
  logic              pre_g, pre_r, pre_s, inc;
  logic [DATA_W:0]   sum;

  assign pre_man = ext_c[STAGES][EXT_W-1:2];
  assign pre_g   = ext_c[STAGES][1];
  assign pre_r   = ext_c[STAGES][0];
  assign pre_s   = sticky_c[STAGES];
  // Round to nearest, ties to even.
  assign inc     = pre_g & (pre_r | pre_s | pre_man[0]);
  assign sum     = {1'b0, pre_man} + {{DATA_W{1'b0}}, inc};

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] man_q,    man_d;
  logic              guard_q,  guard_d;
  logic              round_q,  round_d;
  logic              sticky_q, sticky_d;
  logic              carry_q,  carry_d;

  always_comb begin
    rvalid_d = rvalid_q;
    man_d    = man_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    carry_d  = carry_q;
    if (en) begin
      rvalid_d = valid_c[STAGES];
      man_d    = sum[DATA_W-1:0];
      guard_d  = pre_g;
      round_d  = pre_r;
      sticky_d = pre_s;
      carry_d  = sum[DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      man_q    <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      man_q    <= man_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      carry_q  <= carry_d;
    end
  end

  assign valid_o  = rvalid_q;
  assign man_o    = man_q;
  assign guard_o  = guard_q;
  assign round_o  = round_q;
  assign sticky_o = sticky_q;
  assign carry_o  = carry_q;
`else
  assign valid_o  = valid_c[STAGES];
  assign man_o    = ext_c[STAGES][EXT_W-1:2];
  assign guard_o  = ext_c[STAGES][1];
  assign round_o  = ext_c[STAGES][0];
  assign sticky_o = sticky_c[STAGES];
`endif

  // The whole pipeline moves together: it advances whenever the output slot
  // is empty or being taken.
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

endmodule
`default_nettype wire
